// File: rtl/mem_pkg.sv
// Shared types and defaults for the pipelined memory responder.
// Optional feature macro: MEM_ALIGN_CHECK_EN (adds rsp_err to the top).
package mem_pkg;

    localparam int MEM_DWIDTH    = 16;
    localparam int MEM_AWIDTH    = 16;
    localparam int MEM_LATENCY   = 4;
    localparam int MEM_BURST_LEN = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Slot layout at the default widths; the top packs the same fields at its own widths.
    typedef struct packed {
        logic                  valid;
        logic [MEM_AWIDTH-1:0] addr;
        logic                  last;
        logic [MEM_DWIDTH-1:0] data;
        logic                  err;
    } pipe_slot_t;

    function automatic int burst_idx_w(input int burst_len);
        return $clog2(burst_len);
    endfunction

endpackage

// File: rtl/mem_delay_pipe.sv
// Fixed-depth shift register carrying a valid bit and a payload word per stage.
// Synchronous clear empties every stage and zeroes the payloads.
module mem_delay_pipe #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         any_valid_o
);

    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o     = valid_q[DEPTH-1];
    assign data_o      = data_q[DEPTH-1];
    assign any_valid_o = |valid_q;

endmodule

// File: rtl/mem_responder_mc.sv
// Pipelined main-memory responder: single reads/writes and line bursts, fixed-latency in-order replies.
// Optional feature macro: MEM_ALIGN_CHECK_EN (odd-address requests flagged on rsp_err).
module mem_responder_mc
    import mem_pkg::*;
#(
    parameter int DWIDTH    = MEM_DWIDTH,
    parameter int AWIDTH    = MEM_AWIDTH,
    parameter int LATENCY   = MEM_LATENCY,
    parameter int BURST_LEN = MEM_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_burst,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic [AWIDTH-1:0] rsp_addr,
    output logic              rsp_last,
    output logic              busy
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              rsp_err
`endif
);

    localparam int WW    = AWIDTH - 1;
    localparam int IDX_W = burst_idx_w(BURST_LEN);
    localparam int WORDS = 1 << WW;
    localparam int PW    = WW + 2 + DWIDTH;

    // Request handshake: a request transfers on a rising edge where req_valid & req_ready.
    logic [DWIDTH-1:0]   mem_q [WORDS];
    state_e              state_q;
    logic [IDX_W-1:0]    cnt_q;
    logic [WW-IDX_W-1:0] line_q;
    logic                ready_q;
    logic                berr_q;

    logic              accept;
    logic              misalign;
    logic              wr_commit;
    logic              wr_err;
    logic              issue;
    logic              iss_last;
    logic              iss_err;
    logic              err_in;
    logic [WW-1:0]     iss_idx;
    logic [DWIDTH-1:0] iss_data;
    logic [PW-1:0]     pipe_in;
    logic [PW-1:0]     pipe_out;
    logic              pipe_valid;
    logic              pipe_any;

    assign req_ready = ready_q & ~rst;
    assign accept    = req_valid & req_ready;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = req_addr[0];
`else
    logic unused_addr0;
    assign misalign    = 1'b0;
    assign unused_addr0 = req_addr[0];
`endif

    assign wr_commit = accept & req_wr & ~misalign;
    assign wr_err    = accept & req_wr & misalign;

    // A burst issues its first word in the accepting cycle, the rest from BURST.
    always_comb begin
        issue    = 1'b0;
        iss_idx  = req_addr[AWIDTH-1:1];
        iss_last = 1'b1;
        iss_err  = misalign;
        if (state_q == BURST) begin
            issue    = 1'b1;
            iss_idx  = {line_q, cnt_q};
            iss_last = &cnt_q;
            iss_err  = berr_q;
        end else if (accept && !req_wr) begin
            issue = 1'b1;
            if (req_burst) begin
                iss_idx  = {req_addr[AWIDTH-1:IDX_W+1], {IDX_W{1'b0}}};
                iss_last = 1'b0;
            end
        end
    end

    assign iss_data = iss_err ? '0 : mem_q[iss_idx];
    assign err_in   = (issue & iss_err) | wr_err;
    assign pipe_in  = {iss_idx, iss_last, err_in, iss_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            berr_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && !req_wr && req_burst) begin
                        state_q <= BURST;
                        cnt_q   <= IDX_W'(1);
                        line_q  <= req_addr[AWIDTH-1:IDX_W+1];
                        berr_q  <= misalign;
                        ready_q <= 1'b0;
                    end
                end
                BURST: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem_q[req_addr[AWIDTH-1:1]] <= req_wdata;
        end
    end

    mem_delay_pipe #(
        .DEPTH (LATENCY),
        .W     (PW)
    ) u_pipe (
        .clk_i       (clk),
        .clr_i       (rst),
        .valid_i     (issue),
        .data_i      (pipe_in),
        .valid_o     (pipe_valid),
        .data_o      (pipe_out),
        .any_valid_o (pipe_any)
    );

    assign rsp_valid = pipe_valid;
    assign rsp_rdata = pipe_out[DWIDTH-1:0];
    assign rsp_addr  = {pipe_out[PW-1 -: WW], 1'b0};
    assign rsp_last  = pipe_valid & pipe_out[DWIDTH+1];
    assign busy      = (state_q == BURST) | pipe_any;

`ifdef MEM_ALIGN_CHECK_EN
    assign rsp_err = pipe_out[DWIDTH];
`else
    logic unused_err;
    assign unused_err = pipe_out[DWIDTH];
`endif

endmodule

// File: tb/tb_mem_responder_mc.sv
// Bench for mem_responder_mc: directed steps plus random traffic against a queue-based reference.
// Build with MEM_ALIGN_CHECK_EN defined to also cover rsp_err.
module tb_mem_responder_mc;
    import mem_pkg::*;

    localparam int LAT = 4;
    localparam int BL  = 8;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        int          issue;
        int          due;
        logic        is_rsp;
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic        req_burst = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] rsp_addr;
    logic        rsp_last;
    logic        busy;
`ifdef MEM_ALIGN_CHECK_EN
    logic        rsp_err;
`endif

    int          cyc = 0;
    int          ready_cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        mon_busy;
    logic [15:0] model_mem [256];

    mem_responder_mc #(
        .DWIDTH    (16),
        .AWIDTH    (16),
        .LATENCY   (LAT),
        .BURST_LEN (BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_burst (req_burst),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_addr  (rsp_addr),
        .rsp_last  (rsp_last),
        .busy      (busy)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    // Clock and cycle count (cyc = number of rising edges so far).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: memory array plus a queue of expected responses with their due cycles.
    task automatic model_accept(input logic wr, input logic burst, input logic [15:0] addr,
                                input logic [15:0] wdata, input int a);
        exp_t e;
        int   idx;
        idx      = int'(addr[8:1]);
        e.issue  = a;
        e.due    = a + LAT - 1;
        e.is_rsp = 1'b1;
        e.addr   = {addr[15:1], 1'b0};
        e.data   = '0;
        e.last   = 1'b1;
        e.err    = 1'b0;
        if (wr) begin
            if (ALIGN && addr[0]) begin
                e.is_rsp = 1'b0;
                e.err    = 1'b1;
                exp_q.push_back(e);
            end else begin
                model_mem[idx] = wdata;
            end
        end else if (burst) begin
            int base;
            base = idx - (idx % BL);
            for (int k = 0; k < BL; k++) begin
                e.issue = a + k;
                e.due   = a + k + LAT - 1;
                e.addr  = 16'((base + k) * 2);
                e.data  = model_mem[base + k];
                e.last  = (k == BL - 1);
                exp_q.push_back(e);
            end
            ready_cyc = a + BL - 1;
        end else begin
            e.err  = ALIGN && addr[0];
            e.data = e.err ? 16'h0000 : model_mem[idx];
            exp_q.push_back(e);
        end
    endtask

    task automatic do_req(input logic wr, input logic burst, input logic [15:0] addr,
                          input logic [15:0] wdata);
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        while (!done && guard < 20) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_wr    = wr;
            req_burst = burst;
            req_addr  = addr;
            req_wdata = wdata;
            #1;
            chk("req_ready", 32'(req_ready), 32'(cyc >= ready_cyc));
            if (cyc >= ready_cyc) begin
                model_accept(wr, burst, addr, wdata, cyc + 1);
                done = 1'b1;
            end
            guard++;
            @(posedge clk);
        end
        if (!done) chk("req_accept_timeout", 32'(done), 32'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while ((exp_q.size() > 0 || cyc < ready_cyc) && g < 64) begin
            @(negedge clk);
            g++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(0));
        chk({tag, "_rsp_addr"},  32'(rsp_addr),  32'(0));
        chk({tag, "_rsp_last"},  32'(rsp_last),  32'(0));
        chk({tag, "_busy"},      32'(busy),      32'(0));
        chk({tag, "_state"},     32'(dut.state_q), 32'(IDLE));
`ifdef MEM_ALIGN_CHECK_EN
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'(0));
`endif
    endtask

    // Response monitor: every cycle either the due entry emerges or the channel is quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_busy = (cyc < ready_cyc);
            foreach (exp_q[i]) begin
                if (exp_q[i].is_rsp && exp_q[i].issue <= cyc) mon_busy = 1'b1;
            end
            chk("busy", 32'(busy), 32'(mon_busy));
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.is_rsp));
                if (mon_e.is_rsp) begin
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.data));
                    chk("rsp_addr",  32'(rsp_addr),  32'(mon_e.addr));
                    chk("rsp_last",  32'(rsp_last),  32'(mon_e.last));
                end
`ifdef MEM_ALIGN_CHECK_EN
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
`endif
            end else begin
                chk("rsp_valid_quiet", 32'(rsp_valid), 32'(0));
`ifdef MEM_ALIGN_CHECK_EN
                chk("rsp_err_quiet", 32'(rsp_err), 32'(0));
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset.
        @(negedge clk);
        #1 chk("ready_in_reset", 32'(req_ready), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("por");
        #1 chk("ready_after_reset", 32'(req_ready), 32'(1));
        mon_en = 1'b1;

        // Preload the first 256 words.
        for (int i = 0; i < 256; i++) do_req(1'b1, 1'b0, 16'(i * 2), 16'($urandom));
        drain();

        // Write then read-after-write.
        do_req(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        do_req(1'b0, 1'b0, 16'h0010, 16'h0000);
        drain();

        // Burst from a mid-line address, with a single read held off behind it.
        for (int i = 0; i < 8; i++) do_req(1'b1, 1'b0, 16'(16'h0020 + 2 * i), 16'(16'h1000 + i));
        do_req(1'b0, 1'b1, 16'h0026, 16'h0000);
        do_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        drain();

        // Back-to-back single reads.
        do_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        do_req(1'b0, 1'b0, 16'h0002, 16'h0000);
        do_req(1'b0, 1'b0, 16'h0004, 16'h0000);
        drain();

        // Reset three cycles into a burst, with a write presented during reset.
        do_req(1'b0, 1'b1, 16'h0020, 16'h0000);
        idle(2);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_burst = 1'b0;
        req_addr  = 16'h0030;
        req_wdata = 16'hDEAD;
        #1 chk("ready_mid_reset", 32'(req_ready), 32'(0));
        @(posedge clk);
        exp_q.delete();
        ready_cyc = 0;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        check_reset_outputs("mid_burst_reset");
        #1 chk("ready_after_mid_reset", 32'(req_ready), 32'(1));
        idle(LAT + BL);
        do_req(1'b0, 1'b0, 16'h0026, 16'h0000);
        do_req(1'b0, 1'b0, 16'h0030, 16'h0000);
        drain();

        // Read accepted before a write to the same word keeps the old data.
        do_req(1'b0, 1'b0, 16'h0040, 16'h0000);
        do_req(1'b1, 1'b0, 16'h0040, 16'h5555);
        do_req(1'b0, 1'b0, 16'h0040, 16'h0000);
        drain();

        // Odd addresses: flagged with rsp_err when alignment checking is built in, ignored otherwise.
        do_req(1'b0, 1'b0, 16'h0041, 16'h0000);
        do_req(1'b1, 1'b0, 16'h0043, 16'h1234);
        do_req(1'b0, 1'b0, 16'h0042, 16'h0000);
        drain();

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            int op;
            op = $urandom_range(0, 3);
            case (op)
                0:       do_req(1'b1, 1'b0, 16'($urandom_range(0, 255) * 2), 16'($urandom));
                3:       do_req(1'b0, 1'b1, 16'($urandom_range(0, 255) * 2), 16'h0000);
                default: do_req(1'b0, 1'b0, 16'($urandom_range(0, 255) * 2), 16'h0000);
            endcase
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder_mc.md
Name: mem_responder_mc

Overview:
Multi-cycle, pipelined main-memory responder that serves the processor-side memory initiator (IF fetch path, MEM data path, and the cache-fill controller).
- Accepts single-word reads/writes and line-burst reads over a valid/ready request channel.
- Returns read data in order, after a fixed latency, on a valid-only response channel.
- Replaces the single-cycle memories for the cached processor phase.

Parameters:
DWIDTH, 16, data word width in bits
AWIDTH, 16, byte-address width; storage holds 2^(AWIDTH-1) words
LATENCY, 4, cycles from request acceptance to rsp_valid (>=1)
BURST_LEN, 8, words per burst read; power of two, >=2

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset: synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when req_valid & req_ready
req_wr  in  1  1 = write, 0 = read
req_burst  in  1  1 = burst read of BURST_LEN words; ignored when req_wr=1
req_addr  in  AWIDTH  byte address; word index = req_addr[AWIDTH-1:1]
req_wdata  in  DWIDTH  write data
rsp_valid  out  1  read data valid (no backpressure; initiator always accepts)
rsp_rdata  out  DWIDTH  read data
rsp_addr  out  AWIDTH  byte address of returned word (bit 0 = 0)
rsp_last  out  1  final word of a burst, or any single read
busy  out  1  burst issue in progress or reads in flight

Behaviour:
- Storage: word array indexed by addr[AWIDTH-1:1]. addr[0] is ignored. Contents are not cleared by rst.
- FSM states:
  - IDLE: req_ready=1.
    - Accepted write: array updated at that clock edge; no response.
    - Accepted single read: one slot enters the delay pipe.
    - Accepted read with req_burst=1: go to BURST.
  - BURST: req_ready=0. Issue one internal read per cycle, starting at the line-aligned word (index low log2(BURST_LEN) bits forced to 0), incrementing the low bits only. Issue counter 0..BURST_LEN-1; the first word is issued in the acceptance cycle itself. Return to IDLE after word BURST_LEN-1 is issued.
- Delay pipe:
  - LATENCY-deep shift register of {valid, addr, last}; data is read from the array at issue time and carried with the slot.
  - A read issued at edge T produces rsp_valid high during the cycle after edge T+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
  - Back-to-back issue supported; responses are strictly in issue order.
- Ordering: a write accepted at cycle N is visible to any read accepted at N+1 or later. Reads in flight keep the data sampled at issue.
- rsp_last: 1 on single reads; on bursts, 1 only with word BURST_LEN-1.
- busy = (state==BURST) | any pipe slot valid.
- rsp_rdata/rsp_addr are don't-care when rsp_valid=0; the bench must not check them.
- Reset (sync, any cycle including mid-burst):
  - State -> IDLE; issue counter -> 0; all pipe valids -> 0.
  - Outputs in the cycle after the reset edge: rsp_valid=0, rsp_last=0, rsp_rdata=0, rsp_addr=0, busy=0.
  - req_ready=0 while rst is high; 1 in the first cycle after.
  - Responses in flight are dropped.
  - A write presented with rst high is not committed.
- Simultaneous events: a new request in the cycle a burst finishes issuing is held off (req_ready=0 that cycle). A request in the cycle a response emerges is accepted normally.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: adds output rsp_err (1 bit, reset 0).
  - A read with req_addr[0]=1 returns with rsp_err=1 and rsp_rdata=0.
  - A write with req_addr[0]=1 is dropped. It raises rsp_err for one cycle, LATENCY cycles after acceptance, with rsp_valid=0.
- Undefined: no rsp_err port; addr[0] is silently ignored.

Decomposition:
- Shared package (mem_pkg): state enum {IDLE, BURST}, BURST_IDX_W = log2(BURST_LEN), default LATENCY/BURST_LEN constants, and the pipe-slot struct {valid, addr, last, data[, err]}.
- One natural sub-module, mem_delay_pipe: the parameterised LATENCY-stage shift register with synchronous clear.

Test Plan:
- Write 0xBEEF @0x0010, then read @0x0010 next cycle -> rsp_valid exactly 4 cycles after read acceptance; rsp_rdata=0xBEEF, rsp_addr=0x0010, rsp_last=1.
- Preload words 0x1000+i @0x0020+2i (i=0..7), burst read @0x0026 -> 8 responses on consecutive cycles, addrs 0x0020..0x002E, data 0x1000..0x1007; rsp_last only on 0x002E; req_ready=0 for 7 cycles after acceptance.
- Single reads @0x0000, 0x0002, 0x0004 on three consecutive cycles -> three consecutive responses in the same order, first at +4 cycles, each with rsp_last=1.
- Assert rst 3 cycles into a burst -> in the cycle after the reset edge, rsp_valid=0, busy=0, state IDLE, no further responses; the next single read returns the correct preloaded data.
- Read @0x0040 accepted, then write 0x5555 @0x0040 next cycle -> read returns the old value; a subsequent read returns 0x5555.
- With MEM_ALIGN_CHECK_EN, read @0x0041 -> rsp_valid=1, rsp_err=1, rsp_rdata=0 at +4 cycles. Then write 0x1234 @0x0043 -> rsp_err pulses for one cycle at +4 cycles with rsp_valid=0, and word @0x0042 is unchanged.
